bound_flasher_fp_adder: RTL and testbench

//  Registered IEEE-754 single-precision adder: out = para1 + para2 (true signed add, so mixed signs subtract).

---
 rtl/fp32_pkg.sv | 34 +++
 rtl/lzc24.sv | 15 +
 rtl/bound_flasher_fp_adder.sv | 111 +++++++++++
 tb/tb_bound_flasher_fp_adder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the floating-point ALU: field widths, constants,
// and the unpack/pack helpers used by the adder datapath.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [31:0]      POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [FRAC_W:0]  man;   // significand with the hidden bit restored
    } fp_unpacked_t;

    // Subnormal inputs flush to zero: the hidden bit is present only for exp != 0.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] bits);
        fp_unpacked_t u;
        u.sign = bits[31];
        u.exp  = bits[30:23];
        u.man  = (bits[30:23] != '0) ? {1'b1, bits[22:0]} : '0;
        return u;
    endfunction

    function automatic logic [31:0] fp_pack(input logic sign,
                                            input logic [EXP_W-1:0] exp,
                                            input logic [FRAC_W-1:0] frac);
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/lzc24.sv
// 24-bit leading-zero counter; an all-zero input reports 24.
module lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);

    // Scanning upward lets the highest set bit make the final assignment.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (value[i]) count = 5'(23 - i);
        end
    end

endmodule

// File: rtl/bound_flasher_fp_adder.sv
// Registered binary32 adder (align / add / normalize / round-to-nearest-even, one output register).
// Define FP_SPECIALS_EN to add NaN and infinity handling on the inputs.
module bound_flasher_fp_adder
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] para1,
    input  logic [31:0] para2,
    output logic [31:0] out,
    output logic        under_overflow
);

    fp_unpacked_t op1, op2, a, b;
    logic         swap;
    logic [7:0]   diff;
    logic [49:0]  b_shift;
    logic [26:0]  a_ext, b_ext;
    logic [27:0]  sum;
    logic [4:0]   lz;
    logic [26:0]  norm;
    logic signed [9:0] exp_n, exp_r;
    logic         round_up;
    logic [24:0]  mant_r;
    logic [22:0]  frac_r;
    logic [31:0]  res;
    logic         res_flag;

    assign op1 = fp_unpack(para1);
    assign op2 = fp_unpack(para2);

    // Larger magnitude goes to A so the mantissa subtraction never goes negative.
    assign swap = {op2.exp, op2.man} > {op1.exp, op1.man};
    assign a    = swap ? op2 : op1;
    assign b    = swap ? op1 : op2;
    assign diff = a.exp - b.exp;

    // Working format: 24-bit significand followed by guard, round and sticky bits.
    assign a_ext   = {a.man, 3'b000};
    assign b_shift = {b.man, 26'b0} >> diff;
    assign b_ext   = (diff >= 8'd26) ? {26'b0, |b.man}
                                     : {b_shift[49:24], |b_shift[23:0]};

    assign sum = (a.sign == b.sign) ? {1'b0, a_ext} + {1'b0, b_ext}
                                    : {1'b0, a_ext} - {1'b0, b_ext};

    // An all-zero top field after cancellation can only leave the guard bit set,
    // so the count of 24 moves it straight to the hidden-bit position.
    lzc24 u_lzc (
        .value (sum[26:3]),
        .count (lz)
    );

    always_comb begin
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = $signed({2'b00, a.exp}) + 10'sd1;
        end else begin
            norm  = sum[26:0] << lz;
            exp_n = $signed({2'b00, a.exp}) - $signed({5'b00000, lz});
        end
    end

    assign round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    assign mant_r   = {1'b0, norm[26:3]} + 25'(round_up);
    assign exp_r    = mant_r[24] ? exp_n + 10'sd1 : exp_n;
    assign frac_r   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    always_comb begin
        res      = fp_pack(a.sign, exp_r[7:0], frac_r);
        res_flag = 1'b0;
        if (op1.exp == '0 && op2.exp == '0) begin
            res = {op1.sign & op2.sign, 31'b0};
        end else if (sum == '0) begin
            res = 32'h0000_0000;
        end else if (exp_r >= 10'sd255) begin
            res      = fp_pack(a.sign, EXP_MAX, '0);
            res_flag = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            res      = {a.sign, 31'b0};
            res_flag = 1'b1;
        end
`ifdef FP_SPECIALS_EN
        if ((para1[30:23] == EXP_MAX && para1[22:0] != '0) ||
            (para2[30:23] == EXP_MAX && para2[22:0] != '0) ||
            (para1[30:0] == POS_INF[30:0] && para2[30:0] == POS_INF[30:0] &&
             para1[31] != para2[31])) begin
            res      = QNAN;
            res_flag = 1'b0;
        end else if (para1[30:0] == POS_INF[30:0]) begin
            res      = para1;
            res_flag = 1'b0;
        end else if (para2[30:0] == POS_INF[30:0]) begin
            res      = para2;
            res_flag = 1'b0;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out            <= 32'h0000_0000;
            under_overflow <= 1'b0;
        end else begin
            out            <= res;
            under_overflow <= res_flag;
        end
    end

endmodule

// File: tb/tb_bound_flasher_fp_adder.sv
// Self-checking bench for bound_flasher_fp_adder against an exact-integer RNE reference model.
module tb_bound_flasher_fp_adder;

    logic        clk;
    logic        rst;
    logic [31:0] para1, para2;
    logic [31:0] out;
    logic        under_overflow;

    int checks = 0;
    int errors = 0;

    bound_flasher_fp_adder dut (
        .clk            (clk),
        .rst            (rst),
        .para1          (para1),
        .para2          (para2),
        .out            (out),
        .under_overflow (under_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic signed [299:0] wide_t;

    // Reference: each operand becomes an exact scaled integer, the sum is exact,
    // then it is rounded to 24 significant bits with ties-to-even.
    function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        int          ex, ey, p, e;
        wide_t       vx, vy, s, mag, sh;
        logic [24:0] mant;
        logic        g, st, sgn;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
`ifdef FP_SPECIALS_EN
        if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0))
            return {1'b0, 32'h7FC0_0000};
        if (ex == 255 && ey == 255)
            return (x[31] != y[31]) ? {1'b0, 32'h7FC0_0000} : {1'b0, x};
        if (ex == 255) return {1'b0, x};
        if (ey == 255) return {1'b0, y};
`endif
        if (ex == 0 && ey == 0) return {1'b0, x[31] & y[31], 31'b0};
        vx = '0;
        vy = '0;
        if (ex != 0) begin
            vx[23:0] = {1'b1, x[22:0]};
            vx = vx << (ex - 1);
            if (x[31]) vx = -vx;
        end
        if (ey != 0) begin
            vy[23:0] = {1'b1, y[22:0]};
            vy = vy << (ey - 1);
            if (y[31]) vy = -vy;
        end
        s = vx + vy;
        if (s == 0) return 33'b0;
        sgn = s[299];
        mag = sgn ? -s : s;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (p >= 23) begin
            sh   = mag >> (p - 23);
            mant = sh[24:0];
            g    = 1'b0;
            st   = 1'b0;
            if (p >= 24) begin
                g = mag[p-24];
                for (int i = 0; i < p - 24; i++) st = st | mag[i];
            end
            if (g && (st || mant[0])) mant = mant + 25'd1;
            if (mant[24]) begin
                mant = mant >> 1;
                e    = e + 1;
            end
        end else begin
            sh   = mag << (23 - p);
            mant = sh[24:0];
        end
        if (e >= 255) return {1'b1, sgn, 8'hFF, 23'b0};
        if (e <= 0)   return {1'b1, sgn, 31'b0};
        return {1'b0, sgn, e[7:0], mant[22:0]};
    endfunction

    task automatic apply(input logic [31:0] a, input logic [31:0] b);
        para1 = a;
        para2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            apply(32'h4148_0000, 32'h40A8_0000);
            checks++;
            if (out !== 32'h0 || under_overflow !== 1'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: out=%h flag=%b, required 00000000 flag 0",
                         i, out, under_overflow);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] da [6] = '{32'h4148_0000, 32'h41A2_0000, 32'h4504_D8B4,
                                32'h3F80_0000, 32'h7F7F_FFFF, 32'h0000_0000};
        logic [31:0] db [6] = '{32'h40A8_0000, 32'hC14C_0000, 32'h461B_13F8,
                                32'hBF80_0000, 32'h7F7F_FFFF, 32'h8000_0000};
        logic [31:0] dexp [6] = '{32'h418E_0000, 32'h40F0_0000, 32'h0,
                                  32'h0000_0000, 32'h7F80_0000, 32'h0000_0000};
        logic        dflag [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [32:0] m;
        for (int i = 0; i < 6; i++) begin
            apply(da[i], db[i]);
            m = ref_add(da[i], db[i]);
            if (i == 2) begin
                dexp[i]  = m[31:0];
                dflag[i] = m[32];
            end
            checks++;
            if (out !== dexp[i] || under_overflow !== dflag[i]) begin
                errors++;
                $display("FAIL directed %0d (%h + %h): out=%h flag=%b, required %h flag %b",
                         i, da[i], db[i], out, under_overflow, dexp[i], dflag[i]);
            end
        end
    endtask

    task automatic test_underflow;
        logic [31:0] a = 32'h0080_0001;
        logic [31:0] b = 32'h8080_0000;
        apply(a, b);
        checks++;
        if (out !== 32'h0000_0000 || under_overflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow: out=%h flag=%b, required 00000000 flag 1", out, under_overflow);
        end
        apply(32'h8000_0000, 32'h8000_0000);
        checks++;
        if (out !== 32'h8000_0000 || under_overflow !== 1'b0) begin
            errors++;
            $display("FAIL neg_zero_sum: out=%h flag=%b, required 80000000 flag 0", out, under_overflow);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b;
        logic [32:0] m;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, a[30:23], 23'($urandom)};
            apply(a, b);
            m = ref_add(a, b);
            checks++;
            if (out !== m[31:0] || under_overflow !== m[32]) begin
                errors++;
                $display("FAIL back_to_back %0d (%h + %h): out=%h flag=%b, required %h flag %b",
                         i, a, b, out, under_overflow, m[31:0], m[32]);
            end
        end
    endtask

    task automatic test_reset_priority;
        rst = 1'b1;
        apply(32'h3F80_0000, 32'h3F80_0000);
        checks++;
        if (out !== 32'h0 || under_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: out=%h flag=%b, required 00000000 flag 0", out, under_overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic [32:0] m;
        int          ea, eb, mode;
        for (int i = 0; i < 600; i++) begin
            mode = int'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            ea = int'(a[30:23]);
            case (mode)
                1: begin
                    eb = ea + int'($urandom_range(0, 6)) - 3;
                    if (eb < 0) eb = 0;
                    if (eb > 254) eb = 254;
                    b[30:23] = 8'(eb);
                end
                2: begin
                    b = {~a[31], a[30:23], a[22:0] ^ 23'($urandom_range(0, 15))};
                end
                3: begin
                    ea = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4))
                                                     : int'($urandom_range(250, 254));
                    a[30:23] = 8'(ea);
                    b[30:23] = 8'(ea - int'($urandom_range(0, 1)));
                end
                default: ;
            endcase
            apply(a, b);
            m = ref_add(a, b);
            checks++;
            if (out !== m[31:0] || under_overflow !== m[32]) begin
                errors++;
                $display("FAIL random %0d mode %0d (%h + %h): out=%h flag=%b, required %h flag %b",
                         i, mode, a, b, out, under_overflow, m[31:0], m[32]);
            end
        end
    endtask

`ifdef FP_SPECIALS_EN
    task automatic test_specials;
        logic [31:0] sa [4] = '{32'h7F80_0000, 32'h7FC0_1234, 32'hFF80_0000, 32'h7F80_0000};
        logic [31:0] sb [4] = '{32'hFF80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h7F80_0000};
        logic [31:0] se [4] = '{32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h7F80_0000};
        for (int i = 0; i < 4; i++) begin
            apply(sa[i], sb[i]);
            checks++;
            if (out !== se[i] || under_overflow !== 1'b0) begin
                errors++;
                $display("FAIL specials %0d (%h + %h): out=%h flag=%b, required %h flag 0",
                         i, sa[i], sb[i], out, under_overflow, se[i]);
            end
        end
    endtask
`endif

    initial begin
        rst   = 1'b1;
        para1 = 32'h4148_0000;
        para2 = 32'h40A8_0000;
        test_reset;
        test_directed;
        test_underflow;
        test_back_to_back;
        test_reset_priority;
        test_random;
`ifdef FP_SPECIALS_EN
        test_specials;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
